// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares RAM port B between the CPU data path (requester C) and a peripheral
//   master (requester P). Exactly one access is in flight at a time:
//     write : IDLE -> GNT_x -> IDLE            (2 cycles)
//     read  : IDLE -> GNT_x -> RD_x -> IDLE    (3 cycles)
//   Arbitration on contention is round-robin (PER_PRIORITY=0) or P-first with
//   a starvation guard that forces a C win after STARVE_LIMIT straight losses.
//
// Ports
//   clk, reset                        clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata             C request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid, cpu_rdata    C grant pulse, read-valid pulse, data
//   per_req/we/addr/wdata             P request, same rules as C
//   per_gnt, per_rvalid, per_rdata    P grant pulse, read-valid pulse, data
//   mem_addr_b, mem_data_b, wren_b    RAM port B address / write data / we
//   mem_q_b                           RAM port B read data (1-cycle latency)
//   busy                              high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int PER_PRIORITY = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              per_req,
  input  logic              per_we,
  input  logic [ADDR_W-1:0] per_addr,
  input  logic [DATA_W-1:0] per_wdata,
  output logic              per_gnt,
  output logic              per_rvalid,
  output logic [DATA_W-1:0] per_rdata,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic [DATA_W-1:0] mem_data_b,
  output logic              wren_b,
  input  logic [DATA_W-1:0] mem_q_b,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GNT_C = 3'd1,
    GNT_P = 3'd2,
    RD_C  = 3'd3,
    RD_P  = 3'd4
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'd15;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic       last_p, last_p_nxt;       // 1: P won the most recent grant
  logic [3:0] starve_cnt, starve_nxt;   // consecutive contended losses by C
  logic       grant_c;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_p     <= 1'b1;   // first contention after reset goes to C
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      last_p     <= last_p_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // NOTE: every variable written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    last_p_nxt = last_p;
    starve_nxt = starve_cnt;
    grant_c    = 1'b0;
    cpu_gnt    = 1'b0;
    cpu_rvalid = 1'b0;
    per_gnt    = 1'b0;
    per_rvalid = 1'b0;
    wren_b     = 1'b0;
    mem_addr_b = '0;
    mem_data_b = '0;

    case (state)
      IDLE: begin
        if (cpu_req && per_req) begin
          if (PER_PRIORITY == 0) begin
            grant_c = last_p;                 // alternate on contention
          end else if (starve_cnt >= STARVE_LIM) begin
            grant_c = 1'b1;                   // starvation guard overrides P
          end else begin
            grant_c = 1'b0;
            if (starve_cnt != STARVE_MAX) starve_nxt = starve_cnt + 4'd1;
          end
          state_nxt = grant_c ? GNT_C : GNT_P;
        end else if (cpu_req) begin
          state_nxt = GNT_C;
        end else if (per_req) begin
          state_nxt = GNT_P;
        end

        // Winner bookkeeping; an uncontended P grant leaves starve_cnt alone.
        if (state_nxt == GNT_C) begin
          last_p_nxt = 1'b0;
          starve_nxt = 4'd0;
        end else if (state_nxt == GNT_P) begin
          last_p_nxt = 1'b1;
        end
      end

      GNT_C: begin
        cpu_gnt    = 1'b1;
        mem_addr_b = cpu_addr;
        mem_data_b = cpu_wdata;
        wren_b     = cpu_we;
        state_nxt  = cpu_we ? IDLE : RD_C;
      end

      GNT_P: begin
        per_gnt    = 1'b1;
        mem_addr_b = per_addr;
        mem_data_b = per_wdata;
        wren_b     = per_we;
        state_nxt  = per_we ? IDLE : RD_P;
      end

      RD_C: begin
        cpu_rvalid = 1'b1;
        state_nxt  = IDLE;
      end

      RD_P: begin
        per_rvalid = 1'b1;
        state_nxt  = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Read data is a plain passthrough; the rvalid pulse says who owns it.
  assign cpu_rdata = mem_q_b;
  assign per_rdata = mem_q_b;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Two arbiters driven by the same requester stimulus:
//     u0 : PER_PRIORITY=0 (round-robin)
//     u1 : PER_PRIORITY=1, STARVE_LIMIT=4
//   Each has its own RAM model on port B. A transaction-level model predicts,
//   per instance, when each access is granted, when read data returns and what
//   it must be; a compare loop checks all outputs every negative clock edge.
//   Directed steps add literal expectations (grant order, specific data).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        per_req = 1'b0, per_we = 1'b0;
  logic [15:0] per_addr = '0, per_wdata = '0;

  logic [1:0]  cpu_gnt, cpu_rvalid, per_gnt, per_rvalid, wren_b, busy;
  logic [15:0] cpu_rdata [2];
  logic [15:0] per_rdata [2];
  logic [15:0] mem_addr_b [2];
  logic [15:0] mem_data_b [2];
  logic [15:0] mem_q_b [2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .PER_PRIORITY(0), .STARVE_LIMIT(4)) u0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt[0]), .cpu_rvalid(cpu_rvalid[0]), .cpu_rdata(cpu_rdata[0]),
    .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_gnt(per_gnt[0]), .per_rvalid(per_rvalid[0]), .per_rdata(per_rdata[0]),
    .mem_addr_b(mem_addr_b[0]), .mem_data_b(mem_data_b[0]), .wren_b(wren_b[0]),
    .mem_q_b(mem_q_b[0]), .busy(busy[0]));

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .PER_PRIORITY(1), .STARVE_LIMIT(4)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt[1]), .cpu_rvalid(cpu_rvalid[1]), .cpu_rdata(cpu_rdata[1]),
    .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_gnt(per_gnt[1]), .per_rvalid(per_rvalid[1]), .per_rdata(per_rdata[1]),
    .mem_addr_b(mem_addr_b[1]), .mem_data_b(mem_data_b[1]), .wren_b(wren_b[1]),
    .mem_q_b(mem_q_b[1]), .busy(busy[1]));

  // Power-up RAM content: 0x1234 at word 0x20, zero elsewhere.
  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h20) ? 16'h1234 : 16'h0000;
  endfunction

  // ---------------------------------------------------------------- RAM models
  logic [15:0] ram  [2][256];
  bit          ram_w[2][256];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [7:0] a;
      a = mem_addr_b[i][7:0];
      mem_q_b[i] <= ram_w[i][a] ? ram[i][a] : init_val(a);
      if (wren_b[i]) begin
        ram[i][a]   = mem_data_b[i];
        ram_w[i][a] = 1'b1;
      end
    end
  end

  // ------------------------------------------------------ transaction model
  // Per instance: the cycle number, the one pending access (when it is granted,
  // when its read data is due, when the port is free again) and arbitration
  // history. Cycle 0 is the first cycle after reset release.
  int          m_cyc  [2];
  int          m_gnt  [2];
  int          m_rv   [2];
  int          m_free [2];
  bit          m_who_p[2];
  bit          m_we   [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_wdata[2];
  logic [15:0] m_rdata[2];
  bit          m_last_p[2];
  int          m_starve[2];
  logic [15:0] sh  [2][256];
  bit          sh_w[2][256];

  always @(posedge clk or posedge reset) begin : model
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_cyc[i] = 0; m_gnt[i] = -1; m_rv[i] = -1; m_free[i] = 0;
        m_last_p[i] = 1'b1; m_starve[i] = 0;
      end else begin
        bit win_c, win_p;
        // A write granted in the cycle now ending lands in memory.
        if (m_gnt[i] == m_cyc[i] && m_we[i]) begin
          sh[i][m_addr[i][7:0]]   = m_wdata[i];
          sh_w[i][m_addr[i][7:0]] = 1'b1;
        end
        m_cyc[i]++;
        if (m_cyc[i] - 1 >= m_free[i]) begin
          win_c = 1'b0; win_p = 1'b0;
          if (cpu_req && per_req) begin
            if (i == 0)                win_c = m_last_p[i];
            else if (m_starve[i] >= 4) win_c = 1'b1;
            else if (m_starve[i] < 15) m_starve[i]++;
            win_p = !win_c;
          end else begin
            win_c = cpu_req;
            win_p = per_req;
          end
          if (win_c || win_p) begin
            if (win_c) m_starve[i] = 0;
            m_last_p[i] = win_p;
            m_who_p[i]  = win_p;
            m_we[i]     = win_p ? per_we    : cpu_we;
            m_addr[i]   = win_p ? per_addr  : cpu_addr;
            m_wdata[i]  = win_p ? per_wdata : cpu_wdata;
            m_rdata[i]  = sh_w[i][m_addr[i][7:0]] ? sh[i][m_addr[i][7:0]]
                                                  : init_val(m_addr[i][7:0]);
            m_gnt[i]    = m_cyc[i];
            m_rv[i]     = m_we[i] ? -1 : m_cyc[i] + 1;
            m_free[i]   = m_cyc[i] + (m_we[i] ? 1 : 2);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------- checking
  int    checks = 0;
  int    failures = 0;
  string order [2];
  int    ncgnt [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit g, rv, eb;
        string p;
        p  = $sformatf("u%0d.", i);
        g  = !reset && (m_gnt[i] == m_cyc[i]);
        rv = !reset && (m_rv[i] == m_cyc[i]);
        eb = !reset && (m_gnt[i] >= 0) && (m_cyc[i] >= m_gnt[i]) && (m_cyc[i] < m_free[i]);
        check({p, "cpu_gnt"},    32'(cpu_gnt[i]),    32'(g && !m_who_p[i]));
        check({p, "per_gnt"},    32'(per_gnt[i]),    32'(g &&  m_who_p[i]));
        check({p, "wren_b"},     32'(wren_b[i]),     32'(g && m_we[i]));
        check({p, "mem_addr_b"}, 32'(mem_addr_b[i]), g ? 32'(m_addr[i])  : 32'd0);
        check({p, "mem_data_b"}, 32'(mem_data_b[i]), g ? 32'(m_wdata[i]) : 32'd0);
        check({p, "cpu_rvalid"}, 32'(cpu_rvalid[i]), 32'(rv && !m_who_p[i]));
        check({p, "per_rvalid"}, 32'(per_rvalid[i]), 32'(rv &&  m_who_p[i]));
        check({p, "busy"},       32'(busy[i]),       32'(eb));
        check({p, "cpu_rdata_pass"}, 32'(cpu_rdata[i]), 32'(mem_q_b[i]));
        check({p, "per_rdata_pass"}, 32'(per_rdata[i]), 32'(mem_q_b[i]));
        if (rv)
          check({p, "rdata"}, m_who_p[i] ? 32'(per_rdata[i]) : 32'(cpu_rdata[i]),
                32'(m_rdata[i]));
        if (cpu_gnt[i]) begin order[i] = {order[i], "C"}; ncgnt[i]++; end
        if (per_gnt[i]) order[i] = {order[i], "P"};
      end
    end
  endtask

  // ------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 (IDLE) with all requests low.
  task automatic apply_reset();
    reset = 1'b1;
    cpu_req = 1'b0; per_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic stimulus();
    int base [2];
    int snap [2];

    // Single CPU write.
    apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    @(negedge clk);
    check("reset_busy0", 32'(busy[0]), 32'd0);
    check("reset_wren1", 32'(wren_b[1]), 32'd0);
    tick();                                   // cycle 1
    @(negedge clk);
    check("wr_cpu_gnt",  32'(cpu_gnt[0]), 32'd1);
    check("wr_wren_b",   32'(wren_b[0]), 32'd1);
    check("wr_addr",     32'(mem_addr_b[0]), 32'h0010);
    check("wr_data",     32'(mem_data_b[0]), 32'hBEEF);
    tick();                                   // cycle 2
    cpu_req = 1'b0;
    per_req = 1'b1; per_we = 1'b0; per_addr = 16'h0020;
    @(negedge clk);
    check("wr_busy_done", 32'(busy[0]), 32'd0);

    // Single peripheral read of preloaded word.
    tick();                                   // cycle 3
    @(negedge clk);
    check("rd_per_gnt", 32'(per_gnt[1]), 32'd1);
    tick();                                   // cycle 4
    per_req = 1'b0;
    @(negedge clk);
    check("rd_per_rvalid", 32'(per_rvalid[1]), 32'd1);
    check("rd_per_rdata",  32'(per_rdata[1]), 32'h1234);
    check("rd_cpu_rvalid", 32'(cpu_rvalid[1]), 32'd0);
    tick();

    // Both reading continuously: grants at cycles 1,4,7,10,13.
    apply_reset();
    base[0] = order[0].len(); base[1] = order[1].len();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    per_req = 1'b1; per_we = 1'b0; per_addr = 16'h0020;
    repeat (15) tick();
    cpu_req = 1'b0; per_req = 1'b0;
    repeat (3) tick();
    check_str("rd_order_rr",  order[0].substr(base[0], order[0].len() - 1), "CPCPC");
    check_str("rd_order_pri", order[1].substr(base[1], order[1].len() - 1), "PPPPC");

    // Both writing continuously: grants at odd cycles 1..19.
    apply_reset();
    base[0] = order[0].len(); base[1] = order[1].len();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'hC0C0;
    per_req = 1'b1; per_we = 1'b1; per_addr = 16'h0041; per_wdata = 16'hA0A0;
    repeat (20) tick();
    cpu_req = 1'b0; per_req = 1'b0;
    repeat (3) tick();
    check_str("wr_order_rr",  order[0].substr(base[0], order[0].len() - 1), "CPCPCPCPCP");
    check_str("wr_order_pri", order[1].substr(base[1], order[1].len() - 1), "PPPPCPPPPC");

    // Reset asserted in the middle of a CPU write grant.
    apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h5555;
    tick();                                   // cycle 1, GNT_C
    check("rst_pre_wren", 32'(wren_b[0]), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_wren0",   32'(wren_b[0]),  32'd0);
    check("rst_gnt0",    32'(cpu_gnt[0]), 32'd0);
    check("rst_busy0",   32'(busy[0]),    32'd0);
    check("rst_wren1",   32'(wren_b[1]),  32'd0);
    cpu_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;                          // cycle 0
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
    per_req = 1'b1; per_we = 1'b0; per_addr = 16'h0020;
    tick();                                   // cycle 1
    check("rst_first_rr",  32'(cpu_gnt[0]), 32'd1);
    check("rst_first_pri", 32'(per_gnt[1]), 32'd1);
    cpu_req = 1'b0; per_req = 1'b0;
    tick();                                   // cycle 2, RD
    check("rst_no_write_rvalid", 32'(cpu_rvalid[0]), 32'd1);
    check("rst_no_write_data",   32'(cpu_rdata[0]),  32'h0000);
    tick();                                   // cycle 3, IDLE

    // CPU request pulses for one cycle while P's read is in RD_P.
    snap[0] = ncgnt[0]; snap[1] = ncgnt[1];
    per_req = 1'b1; per_we = 1'b0; per_addr = 16'h0020;
    tick();                                   // GNT_P
    per_req = 1'b0;
    tick();                                   // RD_P
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    tick();                                   // IDLE
    cpu_req = 1'b0;
    repeat (4) tick();
    check("pulse_no_gnt0", 32'(ncgnt[0]), 32'(snap[0]));
    check("pulse_no_gnt1", 32'(ncgnt[1]), 32'(snap[1]));
    check("pulse_idle",    32'(busy),     32'd0);
  endtask

  initial begin
    order[0] = ""; order[1] = "";
    ncgnt[0] = 0;  ncgnt[1] = 0;
    fork
      compare_loop();
      stimulus();
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
